// File: rtl/csr_arb_pkg.sv
// rtl/csr_arb_pkg.sv - shared types and counter-select codes for the CSR access arbiter
package csr_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI1,
        RD_LO,
        RD_HI2,
        RESP
    } state_e;

    localparam logic [1:0] CSR_SEL_CYCLE_LO   = 2'd0;
    localparam logic [1:0] CSR_SEL_CYCLE_HI   = 2'd1;
    localparam logic [1:0] CSR_SEL_INSTRET_LO = 2'd2;
    localparam logic [1:0] CSR_SEL_INSTRET_HI = 2'd3;

    function automatic logic is_read_state(input state_e s);
        return (s == RD_HI1) || (s == RD_LO) || (s == RD_HI2);
    endfunction

endpackage

// File: rtl/csr_access_arbiter_starve.sv
// rtl/csr_access_arbiter_starve.sv - saturating starve counter with registered stall request
module csr_starve_ctr #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_read_i,
    input  logic grant_i,
    output logic stall_req_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;

    // Saturating at the limit keeps the stall asserted until the FSM is finally granted.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_read_i || grant_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stall_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_req_o = stall_q;

endmodule

// File: rtl/csr_access_arbiter.sv
// rtl/csr_access_arbiter.sv - shares the counter read port between pipeline CSR reads and coherent debug reads
module csr_access_arbiter
    import csr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int RETRY_CNT_W  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pipe_csr_req_i,
    input  logic [1:0]             pipe_csr_sel_i,
    output logic [31:0]            pipe_csr_data_o,
    input  logic                   dbg_req_valid_i,
    output logic                   dbg_req_ready_o,
    input  logic                   dbg_req_ctr_i,
    output logic                   dbg_rsp_valid_o,
    input  logic                   dbg_rsp_ready_i,
    output logic [63:0]            dbg_rsp_data_o,
    output logic [1:0]             csr_sel_o,
    input  logic [31:0]            csr_data_i,
    output logic                   stall_req_o,
    output logic [RETRY_CNT_W-1:0] retry_cnt_o
);

    state_e                 state_q, state_d;
    logic                   ctr_q, ctr_d;
    logic [31:0]            hi1_q, hi1_d;
    logic [31:0]            lo_q, lo_d;
    logic [63:0]            rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d;

    logic       in_read;
    logic       fsm_grant;
    logic [1:0] lo_sel;
    logic [1:0] hi_sel;
    logic [1:0] fsm_sel;

    assign in_read   = is_read_state(state_q);
    assign fsm_grant = in_read && (!pipe_csr_req_i || stall_req_o);
    assign lo_sel    = ctr_q ? CSR_SEL_INSTRET_LO : CSR_SEL_CYCLE_LO;
    assign hi_sel    = ctr_q ? CSR_SEL_INSTRET_HI : CSR_SEL_CYCLE_HI;
    assign fsm_sel   = (state_q == RD_LO) ? lo_sel : hi_sel;

    assign csr_sel_o       = fsm_grant ? fsm_sel : pipe_csr_sel_i;
    assign pipe_csr_data_o = csr_data_i;
    assign dbg_req_ready_o = (state_q == IDLE) && !rst_i;
    assign dbg_rsp_valid_o = rsp_valid_q;
    assign dbg_rsp_data_o  = rsp_data_q;
    assign retry_cnt_o     = retry_q;

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        hi1_d      = hi1_q;
        lo_d       = lo_q;
        rsp_data_d = rsp_data_q;
        retry_d    = retry_q;
        case (state_q)
            IDLE: begin
                if (dbg_req_valid_i) begin
                    ctr_d   = dbg_req_ctr_i;
                    state_d = RD_HI1;
                end
            end
            RD_HI1: begin
                if (fsm_grant) begin
                    hi1_d   = csr_data_i;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                if (fsm_grant) begin
                    lo_d    = csr_data_i;
                    state_d = RD_HI2;
                end
            end
            RD_HI2: begin
                if (fsm_grant) begin
                    if (csr_data_i == hi1_q) begin
                        rsp_data_d = {hi1_q, lo_q};
                        state_d    = RESP;
                    end else begin
                        // A carry crossed into the hi word: the new hi becomes the reference and lo is re-read.
                        hi1_d   = csr_data_i;
                        state_d = RD_LO;
                        if (retry_q != '1) begin
                            retry_d = retry_q + RETRY_CNT_W'(1);
                        end
                    end
                end
            end
            RESP: begin
                if (dbg_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ctr_q       <= 1'b0;
            hi1_q       <= '0;
            lo_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            hi1_q       <= hi1_d;
            lo_q        <= lo_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            retry_q     <= retry_d;
        end
    end

    csr_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_read_i  (in_read),
        .grant_i    (fsm_grant),
        .stall_req_o(stall_req_o)
    );

endmodule

// File: tb/tb_csr_access_arbiter.sv
// tb/tb_csr_access_arbiter.sv - self-checking bench with counter-unit model and response scoreboard
module tb_csr_access_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_csr_req_i;
    logic [1:0]  pipe_csr_sel_i;
    logic [31:0] pipe_csr_data_o;
    logic        dbg_req_valid_i;
    logic        dbg_req_ready_o;
    logic        dbg_req_ctr_i;
    logic        dbg_rsp_valid_o;
    logic        dbg_rsp_ready_i;
    logic [63:0] dbg_rsp_data_o;
    logic [1:0]  csr_sel_o;
    logic [31:0] csr_data_i;
    logic        stall_req_o;
    logic [7:0]  retry_cnt_o;

    logic [63:0] cyc_q;
    logic [63:0] ins_q;
    logic        load_en;
    logic [63:0] load_val;
    logic        flush;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    always #5 clk_i = ~clk_i;

    csr_access_arbiter #(
        .STARVE_LIMIT(8),
        .RETRY_CNT_W (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pipe_csr_req_i (pipe_csr_req_i),
        .pipe_csr_sel_i (pipe_csr_sel_i),
        .pipe_csr_data_o(pipe_csr_data_o),
        .dbg_req_valid_i(dbg_req_valid_i),
        .dbg_req_ready_o(dbg_req_ready_o),
        .dbg_req_ctr_i  (dbg_req_ctr_i),
        .dbg_rsp_valid_o(dbg_rsp_valid_o),
        .dbg_rsp_ready_i(dbg_rsp_ready_i),
        .dbg_rsp_data_o (dbg_rsp_data_o),
        .csr_sel_o      (csr_sel_o),
        .csr_data_i     (csr_data_i),
        .stall_req_o    (stall_req_o),
        .retry_cnt_o    (retry_cnt_o)
    );

    // Counter unit model: both counters reset to all-ones, cycle counts every clock,
    // instret counts every cycle the bench does not flag as flushed.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ins_q <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            cyc_q <= load_en ? load_val : cyc_q + 64'd1;
            if (!flush) ins_q <= ins_q + 64'd1;
        end
    end

    always_comb begin
        csr_data_i = cyc_q[31:0];
        case (csr_sel_o)
            2'd0: csr_data_i = cyc_q[31:0];
            2'd1: csr_data_i = cyc_q[63:32];
            2'd2: csr_data_i = ins_q[31:0];
            2'd3: csr_data_i = ins_q[63:32];
            default: csr_data_i = cyc_q[31:0];
        endcase
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic load_cycle(input logic [63:0] v);
        load_en  = 1'b1;
        load_val = v;
        step();
        load_en  = 1'b0;
    endtask

    task automatic send_req(input logic ctr);
        dbg_req_valid_i = 1'b1;
        dbg_req_ctr_i   = ctr;
        #1;
        n_checks++;
        if (dbg_req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready: got %0b, required 1", dbg_req_ready_o);
        end
        step();
        dbg_req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        logic [63:0] exp;
        n = 0;
        while (!dbg_rsp_valid_o && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (dbg_rsp_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: valid=%0b after %0d cycles, required 1", dbg_rsp_valid_o, n);
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: data=%h, required no response", dbg_rsp_data_o);
        end else begin
            exp = exp_q.pop_front();
            if (dbg_rsp_data_o !== exp) begin
                n_fail++;
                $display("FAIL rsp_data: got %h, required %h", dbg_rsp_data_o, exp);
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst_i           = 1'b1;
        pipe_csr_req_i  = 1'b0;
        pipe_csr_sel_i  = 2'd0;
        dbg_req_valid_i = 1'b0;
        dbg_req_ctr_i   = 1'b0;
        dbg_rsp_ready_i = 1'b1;
        load_en         = 1'b0;
        load_val        = '0;
        flush           = 1'b0;
        step();
        step();
        n_checks += 5;
        if (dbg_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b, required 0", dbg_req_ready_o); end
        if (dbg_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b, required 0", dbg_rsp_valid_o); end
        if (dbg_rsp_data_o !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h, required 0", dbg_rsp_data_o); end
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b, required 0", stall_req_o); end
        if (retry_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d, required 0", retry_cnt_o); end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (dbg_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b, required 1", dbg_req_ready_o); end
    endtask

    task automatic test_wrap();
        rst_i = 1'b1;
        flush = 1'b1;
        step();
        rst_i = 1'b0;
        exp_q.push_back(64'h0000_0000_0000_0002);
        send_req(1'b1);
        flush = 1'b0;
        #1;
        n_checks++;
        if (csr_sel_o !== 2'd3) begin n_fail++; $display("FAIL wrap_sel_hi: got %0d, required 3", csr_sel_o); end
        wait_rsp(20);
        n_checks++;
        if (retry_cnt_o !== 8'd1) begin n_fail++; $display("FAIL wrap_retry: got %0d, required 1", retry_cnt_o); end
    endtask

    task automatic test_reset_mid();
        load_cycle(64'h0000_0003_0000_0040);
        send_req(1'b0);
        step();
        n_checks++;
        if (csr_sel_o !== 2'd0) begin n_fail++; $display("FAIL mid_sel_lo: got %0d, required 0", csr_sel_o); end
        rst_i = 1'b1;
        #1;
        n_checks += 4;
        if (dbg_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %0b, required 0", dbg_req_ready_o); end
        if (dbg_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %0b, required 0", dbg_rsp_valid_o); end
        if (retry_cnt_o !== 8'd0) begin n_fail++; $display("FAIL mid_retry: got %0d, required 0", retry_cnt_o); end
        if (dbg_rsp_data_o !== 64'd0) begin n_fail++; $display("FAIL mid_rsp_data: got %h, required 0", dbg_rsp_data_o); end
        step();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (dbg_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_idle_ready: got %0b, required 1", dbg_req_ready_o); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (dbg_rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: cycle %0d valid=%0b, required 0", i, dbg_rsp_valid_o); end
        end
    endtask

    task automatic test_idle_read();
        load_cycle(64'h0000_0001_0000_000E);
        exp_q.push_back(64'h0000_0001_0000_0010);
        send_req(1'b0);
        n_checks++;
        if (csr_sel_o !== 2'd1) begin n_fail++; $display("FAIL idle_sel_hi: got %0d, required 1", csr_sel_o); end
        step();
        n_checks++;
        if (csr_sel_o !== 2'd0) begin n_fail++; $display("FAIL idle_sel_lo: got %0d, required 0", csr_sel_o); end
        wait_rsp(10);
        n_checks++;
        if (retry_cnt_o !== 8'd0) begin n_fail++; $display("FAIL idle_retry: got %0d, required 0", retry_cnt_o); end
    endtask

    task automatic test_pipe_priority();
        load_cycle(64'h0000_0005_0000_0100);
        exp_q.push_back(64'h0000_0005_0000_0105);
        send_req(1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            pipe_csr_req_i = 1'b1;
            pipe_csr_sel_i = 2'(i + 1);
            #1;
            n_checks += 2;
            if (csr_sel_o !== pipe_csr_sel_i) begin n_fail++; $display("FAIL prio_sel: cycle %0d got %0d, required %0d", i, csr_sel_o, pipe_csr_sel_i); end
            if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL prio_stall: cycle %0d got %0b, required 0", i, stall_req_o); end
            step();
        end
        pipe_csr_req_i = 1'b0;
        wait_rsp(10);
    endtask

    task automatic test_starvation();
        int n;
        load_cycle(64'h0000_0007_0000_0200);
        exp_q.push_back(64'h0000_0007_0000_0212);
        send_req(1'b0);
        pipe_csr_req_i = 1'b1;
        pipe_csr_sel_i = 2'd2;
        #1;
        n = 0;
        while (!stall_req_o && n < 20) begin
            step();
            n++;
        end
        n_checks += 2;
        if (n !== 8) begin n_fail++; $display("FAIL starve_cycles: stall after %0d cycles, required 8", n); end
        if (csr_sel_o !== 2'd1) begin n_fail++; $display("FAIL starve_grant_sel: got %0d, required 1", csr_sel_o); end
        step();
        n_checks++;
        if (stall_req_o !== 1'b0) begin n_fail++; $display("FAIL starve_drop: got %0b, required 0", stall_req_o); end
        wait_rsp(40);
        pipe_csr_req_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        dbg_rsp_ready_i = 1'b0;
        load_cycle(64'h0000_0009_0000_0300);
        exp_q.push_back(64'h0000_0009_0000_0302);
        send_req(1'b0);
        n = 0;
        while (!dbg_rsp_valid_o && n < 10) begin
            step();
            n++;
        end
        dbg_req_valid_i = 1'b1;
        dbg_req_ctr_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks += 3;
            if (dbg_rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %0b, required 1", i, dbg_rsp_valid_o); end
            if (exp_q.size() == 0 || dbg_rsp_data_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_data: cycle %0d got %h, required %h", i, dbg_rsp_data_o, 64'h0000_0009_0000_0302);
            end
            if (dbg_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready: cycle %0d got %0b, required 0", i, dbg_req_ready_o); end
            step();
        end
        dbg_rsp_ready_i = 1'b1;
        wait_rsp(2);
        n_checks++;
        if (dbg_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %0b, required 1", dbg_req_ready_o); end
        dbg_req_valid_i = 1'b0;
        step();
        n_checks++;
        if (dbg_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_not_accepted: ready=%0b, required 1", dbg_req_ready_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_wrap();
        test_reset_mid();
        test_idle_read();
        test_pipe_priority();
        test_starvation();
        test_backpressure();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: %0d pending, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
